// File: rtl/rob_pkg.sv
// Shared defaults and tag/count types for the reorder-buffer controller.
package rob_pkg;

    localparam int ROB_ADDR_DEFAULT = 4;

    typedef logic [ROB_ADDR_DEFAULT-1:0] rob_tag_t;
    typedef logic [ROB_ADDR_DEFAULT:0]   rob_cnt_t;

endpackage

// File: rtl/rob_entry_store.sv
// Per-entry payload storage for the ROB: info and result flop arrays,
// two write ports each, two asynchronous read ports at head and head+1.
module rob_entry_store #(
    parameter int ADDR   = 4,
    parameter int DEPTH  = 1 << ADDR,
    parameter int INFO_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              info_we0,
    input  logic [ADDR-1:0]   info_wa0,
    input  logic [INFO_W-1:0] info_wd0,
    input  logic              info_we1,
    input  logic [ADDR-1:0]   info_wa1,
    input  logic [INFO_W-1:0] info_wd1,
    input  logic              res_we0,
    input  logic [ADDR-1:0]   res_wa0,
    input  logic [DATA_W-1:0] res_wd0,
    input  logic              res_we1,
    input  logic [ADDR-1:0]   res_wa1,
    input  logic [DATA_W-1:0] res_wd1,
    input  logic [ADDR-1:0]   rd_addr0,
    input  logic [ADDR-1:0]   rd_addr1,
    output logic [INFO_W-1:0] rd_info0,
    output logic [INFO_W-1:0] rd_info1,
    output logic [DATA_W-1:0] rd_result0,
    output logic [DATA_W-1:0] rd_result1
);

    logic [INFO_W-1:0] info_mem   [DEPTH];
    logic [DATA_W-1:0] result_mem [DEPTH];

    // The controller never aims both ports of one array at the same entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) info_mem[i] <= '0;
        end else begin
            if (info_we0) info_mem[info_wa0] <= info_wd0;
            if (info_we1) info_mem[info_wa1] <= info_wd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) result_mem[i] <= '0;
        end else begin
            if (res_we0) result_mem[res_wa0] <= res_wd0;
            if (res_we1) result_mem[res_wa1] <= res_wd1;
        end
    end

    assign rd_info0   = info_mem[rd_addr0];
    assign rd_info1   = info_mem[rd_addr1];
    assign rd_result0 = result_mem[rd_addr0];
    assign rd_result1 = result_mem[rd_addr1];

endmodule

// File: rtl/rob_ctrl.sv
// Two-wide dispatch / two-wide commit reorder-buffer controller.
// Optional synchronous flush is enabled by defining ROB_FLUSH_EN.
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int ROB_ADDR = ROB_ADDR_DEFAULT,
    parameter int DEPTH    = 1 << ROB_ADDR,
    parameter int INFO_W   = 16,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            disp_valid,
    input  logic [2*INFO_W-1:0]   disp_info,
    output logic                  disp_ready,
    output logic [2*ROB_ADDR-1:0] disp_tag,
    input  logic                  cmpl_valid,
    input  logic [ROB_ADDR-1:0]   cmpl_tag,
    input  logic [DATA_W-1:0]     cmpl_result,
    output logic [1:0]            commit_valid,
    output logic [2*INFO_W-1:0]   commit_info,
    output logic [2*DATA_W-1:0]   commit_result,
    input  logic                  commit_ready,
    input  logic                  flush,
    output logic [ROB_ADDR:0]     count
);

    localparam logic [ROB_ADDR:0] DISP_LIMIT = (ROB_ADDR+1)'(DEPTH - 2);
    localparam logic [ROB_ADDR:0] CNT_ONE    = (ROB_ADDR+1)'(1);

    logic [ROB_ADDR-1:0] head, tail, head_p1, tail_p1, cmpl_off;
    logic [ROB_ADDR:0]   count_next;
    logic [DEPTH-1:0]    done;
    logic                flush_eff;
    logic                disp_fire0, disp_fire1, cmpl_hit;
    logic [1:0]          disp_n, ret_n;

`ifdef ROB_FLUSH_EN
    assign flush_eff = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_eff    = 1'b0;
`endif

    assign head_p1 = head + 1'b1;
    assign tail_p1 = tail + 1'b1;

    assign disp_ready = (count <= DISP_LIMIT);
    assign disp_tag   = {tail_p1, tail};

    // A lone slot-1 request carries no slot-0 partner and is dropped.
    assign disp_fire0 = disp_ready & disp_valid[0] & ~flush_eff;
    assign disp_fire1 = disp_fire0 & disp_valid[1];
    assign disp_n     = {1'b0, disp_fire0} + {1'b0, disp_fire1};

    assign commit_valid[0] = (count != '0) & done[head];
    assign commit_valid[1] = commit_valid[0] & (count > CNT_ONE) & done[head_p1];
    assign ret_n = commit_ready ? ({1'b0, commit_valid[0]} + {1'b0, commit_valid[1]}) : 2'd0;

    // An entry is occupied when its distance from head is below count.
    assign cmpl_off = cmpl_tag - head;
    assign cmpl_hit = cmpl_valid & ({1'b0, cmpl_off} < count) & ~flush_eff;

    assign count_next = count + (ROB_ADDR+1)'(disp_n) - (ROB_ADDR+1)'(ret_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else if (flush_eff) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            head  <= head + ROB_ADDR'(ret_n);
            tail  <= tail + ROB_ADDR'(disp_n);
            count <= count_next;
            if (disp_fire0) done[tail]     <= 1'b0;
            if (disp_fire1) done[tail_p1]  <= 1'b0;
            if (cmpl_hit)   done[cmpl_tag] <= 1'b1;
        end
    end

    rob_entry_store #(
        .ADDR   (ROB_ADDR),
        .DEPTH  (DEPTH),
        .INFO_W (INFO_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .info_we0   (disp_fire0),
        .info_wa0   (tail),
        .info_wd0   (disp_info[INFO_W-1:0]),
        .info_we1   (disp_fire1),
        .info_wa1   (tail_p1),
        .info_wd1   (disp_info[2*INFO_W-1:INFO_W]),
        .res_we0    (cmpl_hit),
        .res_wa0    (cmpl_tag),
        .res_wd0    (cmpl_result),
        .res_we1    (1'b0),
        .res_wa1    ('0),
        .res_wd1    ('0),
        .rd_addr0   (head),
        .rd_addr1   (head_p1),
        .rd_info0   (commit_info[INFO_W-1:0]),
        .rd_info1   (commit_info[2*INFO_W-1:INFO_W]),
        .rd_result0 (commit_result[DATA_W-1:0]),
        .rd_result1 (commit_result[2*DATA_W-1:DATA_W])
    );

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl: random dispatch/complete/commit traffic
// checked against an in-order queue model of the reorder buffer.
module tb_rob_ctrl;
    import rob_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int IW    = 16;
    localparam int DW    = 32;
`ifdef ROB_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic            clk, reset;
    logic [1:0]      disp_valid;
    logic [2*IW-1:0] disp_info;
    logic            disp_ready;
    logic [2*AW-1:0] disp_tag;
    logic            cmpl_valid;
    logic [AW-1:0]   cmpl_tag;
    logic [DW-1:0]   cmpl_result;
    logic [1:0]      commit_valid;
    logic [2*IW-1:0] commit_info;
    logic [2*DW-1:0] commit_result;
    logic            commit_ready;
    logic            flush;
    logic [AW:0]     count;

    rob_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_info     (disp_info),
        .disp_ready    (disp_ready),
        .disp_tag      (disp_tag),
        .cmpl_valid    (cmpl_valid),
        .cmpl_tag      (cmpl_tag),
        .cmpl_result   (cmpl_result),
        .commit_valid  (commit_valid),
        .commit_info   (commit_info),
        .commit_result (commit_result),
        .commit_ready  (commit_ready),
        .flush         (flush),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        rob_tag_t      tag;
        logic [IW-1:0] info;
        bit            done;
    } ent_t;

    typedef struct {
        rob_tag_t      tag;
        logic [IW-1:0] info;
    } exp_t;

    ent_t          mdl_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] res_mdl [DEPTH];
    int            mdl_tail;
    int            compared   = 0;
    int            mismatched = 0;
    bit            mon_on     = 1'b0;

    function automatic void cmp(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [1:0] exp_cv();
        logic [1:0] cv;
        cv[0] = (mdl_q.size() >= 1) && mdl_q[0].done;
        cv[1] = cv[0] && (mdl_q.size() >= 2) && mdl_q[1].done;
        return cv;
    endfunction

    task automatic modelReset();
        mdl_q.delete();
        exp_q.delete();
        mdl_tail = 0;
        for (int i = 0; i < DEPTH; i++) res_mdl[i] = '0;
    endtask

    task automatic checkOutput();
        exp_t e;
        cmp("count", 64'(count), 64'(mdl_q.size()));
        cmp("disp_ready", 64'(disp_ready), 64'((DEPTH - mdl_q.size()) >= 2));
        cmp("disp_tag", 64'(disp_tag), 64'({AW'((mdl_tail + 1) % DEPTH), AW'(mdl_tail)}));
        cmp("commit_valid", 64'(commit_valid), 64'(exp_cv()));
        if (!reset && commit_ready && !(FLUSH_ON && flush)) begin
            for (int k = 0; k < 2; k++) begin
                if (commit_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL commit_underflow: got retire in slot %0d expected none", k);
                    end else begin
                        e = exp_q.pop_front();
                        cmp("commit_info", 64'(commit_info[k*IW +: IW]), 64'(e.info));
                        cmp("commit_result", 64'(commit_result[k*DW +: DW]), 64'(res_mdl[e.tag]));
                    end
                end
            end
        end
    endtask

    always @(negedge clk) if (mon_on) checkOutput();

    task automatic applyStimulus(input logic [1:0] dv, input logic [2*IW-1:0] di,
                                 input bit cv, input rob_tag_t ct, input logic [DW-1:0] cr,
                                 input bit crdy, input bit fl);
        bit         rdy;
        int         nret;
        logic [1:0] cvm;
        disp_valid   = dv;
        disp_info    = di;
        cmpl_valid   = cv;
        cmpl_tag     = ct;
        cmpl_result  = cr;
        commit_ready = crdy;
        flush        = fl;
        @(posedge clk);
        if (FLUSH_ON && fl) begin
            modelReset();
        end else begin
            rdy  = (DEPTH - mdl_q.size()) >= 2;
            cvm  = exp_cv();
            nret = crdy ? (cvm[1] ? 2 : (cvm[0] ? 1 : 0)) : 0;
            if (cv) begin
                foreach (mdl_q[i]) begin
                    if (mdl_q[i].tag == ct) begin
                        mdl_q[i].done = 1'b1;
                        res_mdl[ct]   = cr;
                    end
                end
            end
            repeat (nret) void'(mdl_q.pop_front());
            if (rdy && dv[0]) begin
                for (int s = 0; s < ((dv == 2'b11) ? 2 : 1); s++) begin
                    mdl_q.push_back('{tag: AW'(mdl_tail), info: di[s*IW +: IW], done: 1'b0});
                    exp_q.push_back('{tag: AW'(mdl_tail), info: di[s*IW +: IW]});
                    mdl_tail = (mdl_tail + 1) % DEPTH;
                end
            end
        end
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        disp_valid = '0; disp_info = '0; cmpl_valid = 1'b0; cmpl_tag = '0;
        cmpl_result = '0; commit_ready = 1'b0; flush = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic randomCycle(input int crdy_pct);
        int       pend[$];
        bit       cv;
        rob_tag_t ct;
        cv = 1'b0;
        ct = AW'($urandom_range(0, DEPTH - 1));
        foreach (mdl_q[i]) if (!mdl_q[i].done) pend.push_back(i);
        if (pend.size() > 0 && $urandom_range(0, 99) < 70) begin
            cv = 1'b1;
            ct = mdl_q[pend[$urandom_range(0, pend.size() - 1)]].tag;
        end else begin
            cv = $urandom_range(0, 1) == 1;
        end
        applyStimulus(2'($urandom_range(0, 3)), 32'($urandom), cv, ct, 32'($urandom),
                      $urandom_range(0, 99) < crdy_pct, $urandom_range(0, 99) < 3);
    endtask

    initial begin
        reset = 1'b1;
        disp_valid = '0; disp_info = '0; cmpl_valid = 1'b0; cmpl_tag = '0;
        cmpl_result = '0; commit_ready = 1'b0; flush = 1'b0;
        modelReset();
        #1 mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed opening: two dispatches, out-of-order completion, dual retire.
        applyStimulus(2'b11, {16'h0002, 16'h0001}, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'b00, '0, 1'b1, 4'd1, 32'h0000_00BB, 1'b0, 1'b0);
        applyStimulus(2'b00, '0, 1'b1, 4'd0, 32'h0000_00AA, 1'b0, 1'b0);
        applyStimulus(2'b00, '0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        applyStimulus(2'b10, '1, 1'b1, 4'd7, 32'h1234, 1'b1, 1'b0);

        repeat (200) randomCycle(15);
        repeat (400) randomCycle(80);
        repeat (5) randomCycle(10);
        doReset();
        repeat (300) randomCycle(50);
        repeat (3) applyStimulus(2'b00, '0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
